key_matrix_ctrl: RTL
====================

KEY_MATRIX_CTRL -- requirements
Module: key_matrix_ctrl

Interface
REQ-001 SHALL have parameter NUM_COLS, default 11: number of scan columns.
REQ-002 SHALL have parameter ROW_W, default 8: bits per column.
REQ-003 SHALL have parameter SCAN_COLS, default 9: columns 0..SCAN_COLS-1 feed the any-key detector.
REQ-004 SHALL have parameter ALL_COL, default 4'hF: column code meaning "scan all".
REQ-005 SHALL have parameter FIFO_AW, default 3: event FIFO depth 2**FIFO_AW.
REQ-006 SHALL have ports: one clock; reset is asynchronous and active-low (clk, reset_n).
REQ-007 SHALL have ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- ev_valid  in  1  one-cycle key event strobe
- ev_pressed  in  1  1 = press, 0 = release
- ev_col  in  4  event column
- ev_row  in  3  event row bit index
- overlay  in  NUM_COLS*ROW_W  joystick bits ORed into the matrix (column c at bits c*ROW_W+:ROW_W)
- col_wr  in  1  CPU column-select write strobe
- col_wdata  in  4  column value written
- col_sel  out  4  current column select
- rd_data  out  ROW_W  effective bits of the selected column
- frame_tick  in  1  one-cycle VDP frame-interrupt edge
- irq_mode  in  1  0 = matrix-change IRQ, 1 = FIFO-nonempty IRQ
- int_n  out  1  active-low CPU interrupt
- fifo_rd  in  1  pop strobe
- fifo_dout  out  8  head entry {pressed, col[3:0], row[2:0]}
- fifo_empty  out  1  FIFO empty
- fifo_ovf  out  1  sticky overflow
- fifo_clr  in  1  flush FIFO and clear fifo_ovf

Function
REQ-008 SHALL hold a NUM_COLS x ROW_W matrix register; ev_valid with ev_col<NUM_COLS and ev_row<ROW_W sets (press) or clears (release) that bit the next cycle.
REQ-009 SHALL ignore out-of-range events entirely: no matrix change, no FIFO push.
REQ-010 SHALL define effective matrix = matrix | overlay, combinational.
REQ-011 SHALL drive rd_data = effective[col_sel], 0-cycle latency, or 0 when col_sel >= NUM_COLS, including ALL_COL.
REQ-012 SHALL load col_sel from col_wdata one cycle after col_wr.
REQ-013 SHALL compute any_key = OR of effective columns 0..SCAN_COLS-1.
REQ-014 SHALL, in mode 0, on frame_tick with col_sel == ALL_COL: assert int_n low if any_key=1 and any_key_prev=0, then update any_key_prev <= any_key; ticks while col_sel != ALL_COL leave any_key_prev unchanged.
REQ-015 SHALL, in mode 0, release int_n (high) on col_wr.
REQ-016 SHALL give set priority when col_wr and an int_n set condition occur in the same cycle, so int_n is low afterwards.
REQ-017 SHALL, in mode 1, drive int_n = fifo_empty as a level; the mode-0 latch keeps running but is not output.
REQ-018 SHALL push {ev_pressed, ev_col, ev_row} only when a valid in-range event changes the matrix bit; duplicate presses and duplicate releases are not pushed.
REQ-019 SHALL, when full, drop a push and set fifo_ovf, unless fifo_rd is active in the same cycle, in which case both pop and push occur.
REQ-020 SHALL ignore fifo_rd while empty; when empty with simultaneous push and pop, the push is taken.
REQ-021 SHALL drive fifo_dout as the head entry with 0-cycle latency and 8'h00 when empty.
REQ-022 SHALL, on fifo_clr, empty the FIFO and clear fifo_ovf; fifo_clr overrides a same-cycle push or pop.
REQ-023 SHALL update FIFO pointers modulo 2**FIFO_AW, with an extra bit to distinguish full from empty.

Reset
REQ-024 SHALL, on reset_n low, asynchronously clear the matrix, col_sel=0, any_key_prev=0, int_n=1, FIFO empty, fifo_ovf=0.
REQ-025 SHALL discard any event or strobe coincident with reset_n low; operation resumes on the first clock edge after deassertion.

Verification
REQ-026 SHALL be verified by: press (col 2, row 5), col_wr 2 -> rd_data = 8'h20; release -> 8'h00.
REQ-027 SHALL be verified by: col_sel=F, mode 0, press (0,0), frame_tick -> int_n=0; second tick -> int_n stays 0; col_wr 0 -> int_n=1.
REQ-028 SHALL be verified by: overlay bit (6,1) set, col_sel=6 -> rd_data = 8'h02 with an empty matrix; the FIFO stays empty.
REQ-029 SHALL be verified by: 9 distinct presses with FIFO_AW=3 -> 8 entries, fifo_ovf=1, first fifo_dout = {1, col, row} of the first press.
REQ-030 SHALL be verified by: push and pop on the same cycle when full -> count stays 8 and fifo_ovf stays 0.
REQ-031 SHALL be verified by: reset_n pulsed low mid-burst with 3 entries and int_n=0 -> fifo_empty=1, int_n=1, rd_data=0 immediately.

Source files
------------

// File: rtl/key_matrix_ctrl.sv
// Keyboard matrix controller: event-driven key matrix with joystick overlay, CPU column
// readback, frame-sampled any-key interrupt and a press/release event FIFO.
module key_matrix_ctrl #(
   parameter int unsigned NUM_COLS  = 11,
   parameter int unsigned ROW_W     = 8,
   parameter int unsigned SCAN_COLS = 9,
   parameter logic [3:0]  ALL_COL   = 4'hF,
   parameter int unsigned FIFO_AW   = 3
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ev_valid,
   input  logic                      ev_pressed,
   input  logic [3:0]                ev_col,
   input  logic [2:0]                ev_row,
   input  logic [NUM_COLS*ROW_W-1:0] overlay,
   input  logic                      col_wr,
   input  logic [3:0]                col_wdata,
   output logic [3:0]                col_sel,
   output logic [ROW_W-1:0]          rd_data,
   input  logic                      frame_tick,
   input  logic                      irq_mode,
   output logic                      int_n,
   input  logic                      fifo_rd,
   output logic [7:0]                fifo_dout,
   output logic                      fifo_empty,
   output logic                      fifo_ovf,
   input  logic                      fifo_clr
);

   localparam int unsigned Depth = 1 << FIFO_AW;
   typedef logic [FIFO_AW:0] ptr_t;

   logic [NUM_COLS-1:0][ROW_W-1:0] matrix_q, matrix_d, effective;
   logic [3:0] col_sel_q, col_sel_d;
   logic       any_key, tick_scan, irq_set;
   logic       any_key_prev_q, any_key_prev_d;
   logic       irq_q, irq_d;
   logic       ev_hit, ev_push;
   logic       fifo_full, fifo_pop, fifo_push;
   ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic       ovf_q, ovf_d;
   logic [7:0] mem_q [Depth];

   // Only events that actually flip a matrix bit are logged.
   assign ev_hit  = ev_valid && (32'(ev_col) < NUM_COLS) && (32'(ev_row) < ROW_W);
   assign ev_push = ev_hit && (matrix_q[ev_col][ev_row] != ev_pressed);

   assign effective = matrix_q | overlay;
   assign any_key   = |effective[SCAN_COLS-1:0];
   assign rd_data   = (32'(col_sel_q) < NUM_COLS) ? effective[col_sel_q] : '0;
   assign col_sel   = col_sel_q;

   always_comb begin
      matrix_d = matrix_q;
      if (ev_hit) begin
         matrix_d[ev_col][ev_row] = ev_pressed;
      end
   end

   assign col_sel_d = col_wr ? col_wdata : col_sel_q;

   // Any-key edge is only sampled while the CPU has selected all columns.
   always_comb begin
      tick_scan      = frame_tick && (col_sel_q == ALL_COL);
      irq_set        = tick_scan && any_key && !any_key_prev_q;
      any_key_prev_d = tick_scan ? any_key : any_key_prev_q;
      if (irq_set) begin
         irq_d = 1'b1;
      end else if (col_wr) begin
         irq_d = 1'b0;
      end else begin
         irq_d = irq_q;
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {FIFO_AW{1'b0}}});
   assign fifo_pop   = fifo_rd && !fifo_empty;
   assign fifo_push  = ev_push && (!fifo_full || fifo_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (fifo_clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
      end else begin
         if (fifo_pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
         if (fifo_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
         if (ev_push && !fifo_push) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         matrix_q       <= '0;
         col_sel_q      <= '0;
         any_key_prev_q <= 1'b0;
         irq_q          <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         ovf_q          <= 1'b0;
      end else begin
         matrix_q       <= matrix_d;
         col_sel_q      <= col_sel_d;
         any_key_prev_q <= any_key_prev_d;
         irq_q          <= irq_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         ovf_q          <= ovf_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (fifo_push && !fifo_clr) begin
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {ev_pressed, ev_col, ev_row};
      end
   end

   assign fifo_dout = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign fifo_ovf  = ovf_q;
   assign int_n     = irq_mode ? fifo_empty : !irq_q;

endmodule
